// File: rtl/divider_pkg.sv
// Shared types and helpers for the serial restoring divider.
//   state_e   : divider FSM states (idle / iterating / result held)
//   cnt_width : width of the step counter needed to hold the value 'width'
//   CNT_W     : counter width for the default 8-bit operand width
package divider_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StBusy = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  localparam int unsigned DEFAULT_WIDTH = 8;
  localparam int unsigned CNT_W         = cnt_width(DEFAULT_WIDTH);

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration, purely combinational.
// The partial remainder is shifted left with the next dividend bit appended,
// and the divisor is subtracted over WIDTH+1 bits with a ripple adder fed
// the inverted divisor and carry-in 1. A carry-out means no borrow.
// Ports:
//   i_rem     : current partial remainder (always < divisor when divisor != 0)
//   i_bit     : next dividend bit, MSB first
//   i_divisor : divisor magnitude
//   o_rem     : updated partial remainder
//   o_qbit    : quotient bit produced by this step
module div_step #(
  parameter int unsigned WIDTH = 8
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic             i_bit,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic             o_qbit
);

  logic [WIDTH:0]   w_a;
  logic [WIDTH:0]   w_b;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH+1:0] w_carry;

  assign w_a        = {i_rem, i_bit};
  assign w_b        = ~{1'b0, i_divisor};
  assign w_carry[0] = 1'b1;

  for (genvar gi = 0; gi <= WIDTH; gi++) begin : g_rca
    assign w_carry[gi+1] = (w_a[gi] & w_b[gi]) | (w_carry[gi] & (w_a[gi] ^ w_b[gi]));
    // The top sum bit is always zero after a successful subtract, so it is not kept.
    if (gi < WIDTH) begin : g_sum
      assign w_sum[gi] = w_a[gi] ^ w_b[gi] ^ w_carry[gi];
    end
  end

  assign o_qbit = w_carry[WIDTH+1];
  // On a borrow the shifted value is below the divisor, so it fits in WIDTH bits.
  assign o_rem  = o_qbit ? w_sum : w_a[WIDTH-1:0];

endmodule

// File: rtl/serial_divider.sv
// Multi-cycle restoring divider, one quotient bit per clock, valid/ready on
// both sides. Latency is WIDTH+1 cycles from the accept cycle; a result is
// held until the consumer takes it, then one idle cycle precedes the next accept.
// Build option: SERIAL_DIVIDER_SIGNED_EN selects two's complement operands and
// results (magnitudes taken at accept, sign fix-up on the DONE transition).
// Ports:
//   i_clk, i_rst              : clock, synchronous active-high reset
//   i_in_valid / o_in_ready   : operand handshake (ready only in idle)
//   i_dividend, i_divisor     : operands, sampled only on the idle handshake
//   o_out_valid / i_out_ready : result handshake
//   o_quotient, o_remainder   : result, updated only when entering DONE
//   o_div_by_zero             : captured divisor was zero
module serial_divider
  import divider_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_dividend,
  input  logic [WIDTH-1:0] i_divisor,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_quotient,
  output logic [WIDTH-1:0] o_remainder,
  output logic             o_div_by_zero
);

  localparam int unsigned CntW = cnt_width(WIDTH);

  state_e           r_state, w_state_next;
  logic [CntW-1:0]  r_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;  // dividend bits shift out the top, quotient bits in the bottom
  logic [WIDTH-1:0] r_dsr;
  logic             r_dbz_cap;
  logic [WIDTH-1:0] r_quotient;
  logic [WIDTH-1:0] r_remainder;
  logic             r_div_by_zero;

  logic             w_accept;
  logic             w_last;
  logic [WIDTH-1:0] w_step_rem;
  logic             w_qbit;
  logic [WIDTH-1:0] w_quo_u;
  logic [WIDTH-1:0] w_quo_fin;
  logic [WIDTH-1:0] w_rem_fin;
  logic [WIDTH-1:0] w_dvd_mag;
  logic [WIDTH-1:0] w_dsr_mag;

  div_step #(
    .WIDTH(WIDTH)
  ) u_div_step (
    .i_rem    (r_rem),
    .i_bit    (r_quo[WIDTH-1]),
    .i_divisor(r_dsr),
    .o_rem    (w_step_rem),
    .o_qbit   (w_qbit)
  );

  assign w_quo_u = {r_quo[WIDTH-2:0], w_qbit};

`ifdef SERIAL_DIVIDER_SIGNED_EN
  logic             r_neg_q;
  logic             r_neg_r;
  logic [WIDTH-1:0] r_dvd_raw;

  assign w_dvd_mag = i_dividend[WIDTH-1] ? -i_dividend : i_dividend;
  assign w_dsr_mag = i_divisor[WIDTH-1] ? -i_divisor : i_divisor;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_neg_q   <= 1'b0;
      r_neg_r   <= 1'b0;
      r_dvd_raw <= '0;
    end else if (w_accept) begin
      r_neg_q   <= i_dividend[WIDTH-1] ^ i_divisor[WIDTH-1];
      r_neg_r   <= i_dividend[WIDTH-1];
      r_dvd_raw <= i_dividend;
    end
  end

  // Divide by zero reports the raw dividend whatever its sign; -2^(W-1)/-1
  // wraps naturally to -2^(W-1) because the magnitude is 2^(W-1).
  always_comb begin
    w_quo_fin = r_neg_q ? -w_quo_u : w_quo_u;
    w_rem_fin = r_neg_r ? -w_step_rem : w_step_rem;
    if (r_dbz_cap) begin
      w_quo_fin = '1;
      w_rem_fin = r_dvd_raw;
    end
  end
`else
  assign w_dvd_mag = i_dividend;
  assign w_dsr_mag = i_divisor;
  assign w_quo_fin = w_quo_u;
  assign w_rem_fin = w_step_rem;
`endif

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    o_in_ready   = 1'b0;
    o_out_valid  = 1'b0;
    w_accept     = 1'b0;
    w_last       = 1'b0;
    unique case (r_state)
      StIdle: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_accept     = 1'b1;
          w_state_next = StBusy;
        end
      end
      StBusy: begin
        if (r_cnt == CntW'(1)) begin
          w_last       = 1'b1;
          w_state_next = StDone;
        end
      end
      StDone: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_cnt         <= '0;
      r_rem         <= '0;
      r_quo         <= '0;
      r_dsr         <= '0;
      r_dbz_cap     <= 1'b0;
      r_quotient    <= '0;
      r_remainder   <= '0;
      r_div_by_zero <= 1'b0;
    end else if (w_accept) begin
      r_cnt     <= CntW'(WIDTH);
      r_rem     <= '0;
      r_quo     <= w_dvd_mag;
      r_dsr     <= w_dsr_mag;
      r_dbz_cap <= (i_divisor == '0);
    end else if (r_state == StBusy) begin
      r_cnt <= r_cnt - CntW'(1);
      r_rem <= w_step_rem;
      r_quo <= w_quo_u;
      if (w_last) begin
        r_quotient    <= w_quo_fin;
        r_remainder   <= w_rem_fin;
        r_div_by_zero <= r_dbz_cap;
      end
    end
  end

  assign o_quotient    = r_quotient;
  assign o_remainder   = r_remainder;
  assign o_div_by_zero = r_div_by_zero;

endmodule

// File: tb/tb_serial_divider.sv
module tb_serial_divider;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  int n_vec  = 0;
  int n_fail = 0;

  serial_divider #(
    .WIDTH(W)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_in_valid   (in_valid),
    .o_in_ready   (in_ready),
    .i_dividend   (dividend),
    .i_divisor    (divisor),
    .o_out_valid  (out_valid),
    .i_out_ready  (out_ready),
    .o_quotient   (quotient),
    .o_remainder  (remainder),
    .o_div_by_zero(div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model straight from the arithmetic definition.
  task automatic model(input logic [W-1:0] a, input logic [W-1:0] b,
                       output logic [W-1:0] q, output logic [W-1:0] r, output logic z);
    int sa, sb, iq, ir;
    z = (b == '0);
    if (z) begin
      q = '1;
      r = a;
    end else begin
`ifdef SERIAL_DIVIDER_SIGNED_EN
      sa = int'($signed(a));
      sb = int'($signed(b));
`else
      sa = int'(a);
      sb = int'(b);
`endif
      iq = sa / sb;
      ir = sa % sb;
      q  = iq[W-1:0];
      r  = ir[W-1:0];
    end
  endtask

  // Runs one operation starting at a negedge in IDLE. out_ready is held low
  // for 'hold' cycles in DONE while garbage operands are offered.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input int hold);
    logic [W-1:0] eq, er;
    logic ez;
    int lat;
    model(a, b, eq, er, ez);
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid  = 1'b1;
    dividend  = a;
    divisor   = b;
    out_ready = (hold == 0);
    @(posedge clk);
    @(negedge clk);
    lat = 0;
    while (!out_valid && lat < 40) begin
      // Offers during BUSY must be ignored.
      dividend = W'($urandom);
      divisor  = W'($urandom);
      chk("in_ready_busy", 32'(in_ready), 32'd0);
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(W));
    chk("quotient", 32'(quotient), 32'(eq));
    chk("remainder", 32'(remainder), 32'(er));
    chk("div_by_zero", 32'(div_by_zero), 32'(ez));
    if (hold == 0) in_valid = 1'b0;
    for (int i = 0; i < hold; i++) begin
      dividend = W'($urandom);
      divisor  = W'($urandom);
      @(posedge clk);
      @(negedge clk);
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_ready", 32'(in_ready), 32'd0);
      chk("hold_q", 32'(quotient), 32'(eq));
      chk("hold_r", 32'(remainder), 32'(er));
      if (i == hold - 1) begin
        in_valid  = 1'b0;
        out_ready = 1'b1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("post_valid", 32'(out_valid), 32'd0);
    chk("post_q_held", 32'(quotient), 32'(eq));
  endtask

  initial begin
    logic [W-1:0] ra, rb;
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = '0;
    divisor   = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_quotient", 32'(quotient), 32'd0);
    chk("rst_remainder", 32'(remainder), 32'd0);
    chk("rst_dbz", 32'(div_by_zero), 32'd0);

`ifdef SERIAL_DIVIDER_SIGNED_EN
    run_op(8'hF9, 8'd2, 0);     // -7 / 2
    run_op(8'h80, 8'hFF, 0);    // -128 / -1
    run_op(8'd7, 8'hFE, 1);     // 7 / -2
    run_op(8'hFB, 8'd0, 0);     // -5 / 0
`else
    run_op(8'd100, 8'd7, 0);
    run_op(8'd5, 8'd0, 0);
    run_op(8'd255, 8'd1, 0);
    run_op(8'd3, 8'd200, 0);
    run_op(8'd200, 8'd13, 3);
`endif

    // Reset on the fourth BUSY cycle discards the operation and clears results.
    in_valid  = 1'b1;
    dividend  = 8'd77;
    divisor   = 8'd5;
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_quotient", 32'(quotient), 32'd0);
    chk("midrst_remainder", 32'(remainder), 32'd0);
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk("midrst_no_output", 32'(out_valid), 32'd0);
    end
    run_op(8'd9, 8'd4, 0);

    for (int n = 0; n < 24; n++) begin
      ra = W'($urandom);
      rb = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      run_op(ra, rb, int'($urandom_range(0, 2)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_divider.md
# serial_divider

Multi-cycle unsigned restoring divider, one quotient bit per clock, with valid/ready handshakes on both sides. It is the inverse companion to the adder primitives: it reuses a ripple subtract chain (adder with inverted operand and carry-in 1) inside each iteration. It sits beside the systolic MAC datapath for normalisation and scaling, where area matters more than latency.

## Interface
- `WIDTH`, default 8: operand, quotient and remainder width; must be ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: dividend/divisor presented.
- `in_ready` out 1: block accepts an operation this cycle.
- `dividend` in WIDTH: numerator.
- `divisor` in WIDTH: denominator.
- `out_valid` out 1: result held on outputs.
- `out_ready` in 1: consumer takes result.
- `quotient` out WIDTH: result quotient.
- `remainder` out WIDTH: result remainder.
- `div_by_zero` out 1: captured divisor was zero.

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: `in_ready`=1. If `in_valid`, capture operands, clear partial remainder, load step counter = WIDTH, go BUSY.
- BUSY: each cycle, shift {rem, quo} left by one, bringing in the dividend MSB; trial = rem − divisor over WIDTH+1 bits; if no borrow, rem = trial and quotient LSB = 1, else keep rem and LSB = 0. Decrement counter; go DONE after step WIDTH.
- DONE: `out_valid`=1, outputs stable. If `out_ready`, go IDLE. A new operation is not accepted in the same cycle.
- Divide by zero takes the normal path and needs no special case: quotient = all ones, remainder = dividend, `div_by_zero`=1.
- `in_valid` in BUSY or DONE is ignored. Operands are sampled only on an IDLE handshake.
- `quotient`, `remainder` and `div_by_zero` change only when entering DONE, and hold until the next DONE.

## Timing
- Reset values: `in_ready`=1 (IDLE), `out_valid`=0, `quotient`=0, `remainder`=0, `div_by_zero`=0. The counter and internal registers are cleared.
- Accept on edge t. Iteration edges are t+1 … t+WIDTH. `out_valid` is high from edge t+WIDTH, so latency is WIDTH+1 cycles from the accept cycle.
- Throughput: at best one operation per WIDTH+2 cycles (one bubble in IDLE after DONE).
- `rst` in any state: the next cycle is IDLE and the in-flight operation is discarded with no output.
- `out_ready` held low: stay in DONE indefinitely. `in_ready` stays 0.

## Configuration
- `SERIAL_DIVIDER_SIGNED_EN` defined: operands and results are two's complement.
  - Magnitudes are taken at accept.
  - Quotient sign = sign(dividend) XOR sign(divisor); remainder sign = sign(dividend); rounding is truncation toward zero.
  - Sign fix-up happens on the DONE transition, so latency is unchanged.
  - Overflow −2^(WIDTH−1) / −1 gives quotient −2^(WIDTH−1) and remainder 0.
  - Divide by zero gives quotient all ones and remainder = dividend, regardless of sign.
- Not defined: unsigned only, and no sign logic is generated.

## Structure
- Package `divider_pkg`:
  - FSM state enum (IDLE/BUSY/DONE).
  - `CNT_W` = $clog2(WIDTH+1) and a function computing it.
- Sub-module `div_step`, combinational, one restoring iteration:
  - Inputs: rem, next dividend bit, divisor.
  - Outputs: new rem, quotient bit.
  - Built as an inverted-operand adder chain with carry-in 1.
- The top level holds the FSM, counter, operand and result registers, and signed fix-up.

## Test plan
- WIDTH=8, 100/7, `out_ready`=1 → `out_valid` rises 9 cycles after the accept cycle; quotient 14, remainder 2, `div_by_zero` 0.
- 5/0 → quotient 0xFF, remainder 5, `div_by_zero` 1; same latency.
- 255/1 and 3/200 → (255, 0) and (0, 3). Back-to-back `in_valid` → second accept exactly one cycle after the first DONE handshake.
- Hold `out_ready`=0 for 3 cycles in DONE with `in_valid`=1 and changing operands → outputs stable, `in_ready` 0, no second accept. Release → IDLE next cycle.
- Assert `rst` on the 4th BUSY cycle → next cycle IDLE, `out_valid` 0, results 0. A subsequent 9/4 yields (2, 1).
- Signed build: −7/2 → (0xFD, 0xFF); −128/−1 → (0x80, 0x00); 7/−2 → (0xFD, 0x01).
